// File: rtl/sd_spi_arbiter.sv
// Routes one core-side SPI master to either a physical or a virtual SD card.
// Target changes wait until spi_cs has been high long enough, and an activity counter drives the LEDs.
module sd_spi_arbiter #(
   parameter int SWITCH_GUARD = 16,
   parameter int ACT_TIMEOUT  = 1000000
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       img_mounted,
   input  logic       img_present,
   input  logic       spi_sck,
   input  logic       spi_mosi,
   input  logic       spi_cs,
   output logic       spi_miso,
   input  logic       phys_miso,
   input  logic       virt_miso,
   output logic       phys_sck,
   output logic       phys_mosi,
   output logic       phys_cs,
   output logic       virt_cs,
   output logic       virt_sel,
   output logic       switch_pending,
   output logic       switch_done,
   output logic       sd_act,
   output logic       led_virt,
   output logic       led_phys,
   output logic [1:0] dbg_state_o
);

   localparam int GW = $clog2(SWITCH_GUARD) + 1;
   localparam int AW = $clog2(ACT_TIMEOUT + 1);
   localparam logic [GW-1:0] GUARD_LAST = GW'(SWITCH_GUARD - 1);
   localparam logic [AW-1:0] ACT_MAX    = AW'(ACT_TIMEOUT);

   typedef enum logic [1:0] {
      S_PHYS  = 2'd0,
      S_VIRT  = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            virt_sel_q, virt_sel_d;
   logic            target_q, target_d;
   logic [GW-1:0]   guard_q, guard_d;
   logic            done_q, done_d;
   logic            pending_q;
   logic            mosi_q, miso_q;
   logic [AW-1:0]   act_cnt_q, act_cnt_d;
   logic            sd_act_q;
   logic            act_change;
   state_e          home_state;

   assign home_state = virt_sel_q ? S_VIRT : S_PHYS;

   always_comb begin
      state_d    = state_q;
      virt_sel_d = virt_sel_q;
      target_d   = target_q;
      guard_d    = guard_q;
      done_d     = 1'b0;
      case (state_q)
         S_PHYS, S_VIRT: begin
            if (img_mounted && (img_present != virt_sel_q)) begin
               target_d = img_present;
               guard_d  = '0;
               state_d  = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // A fresh mount wins over a commit landing in the same cycle.
            if (img_mounted) begin
               target_d = img_present;
               guard_d  = '0;
               if (img_present == virt_sel_q) state_d = home_state;
            end else if (!spi_cs) begin
               guard_d = '0;
            end else if (guard_q >= GUARD_LAST) begin
               virt_sel_d = target_q;
               done_d     = 1'b1;
               guard_d    = '0;
               state_d    = target_q ? S_VIRT : S_PHYS;
            end else begin
               guard_d = guard_q + 1'b1;
            end
         end
         default: state_d = S_PHYS;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= S_PHYS;
         virt_sel_q <= 1'b0;
         target_q   <= 1'b0;
         guard_q    <= '0;
         done_q     <= 1'b0;
         pending_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         virt_sel_q <= virt_sel_d;
         target_q   <= target_d;
         guard_q    <= guard_d;
         done_q     <= done_d;
         pending_q  <= (state_d == S_DRAIN);
      end
   end

   assign act_change = (spi_mosi != mosi_q) || (spi_miso != miso_q);

   always_comb begin
      act_cnt_d = act_cnt_q;
      if (act_change)              act_cnt_d = '0;
      else if (act_cnt_q < ACT_MAX) act_cnt_d = act_cnt_q + 1'b1;
   end

   // Counter starts at zero so the indicator is lit for ACT_TIMEOUT cycles after reset.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         mosi_q    <= 1'b0;
         miso_q    <= 1'b0;
         act_cnt_q <= '0;
         sd_act_q  <= 1'b1;
      end else begin
         mosi_q    <= spi_mosi;
         miso_q    <= spi_miso;
         act_cnt_q <= act_cnt_d;
         sd_act_q  <= (act_cnt_d < ACT_MAX);
      end
   end

   assign phys_cs        = spi_cs | virt_sel_q;
   assign phys_sck       = spi_sck & ~virt_sel_q;
   assign phys_mosi      = spi_mosi & ~virt_sel_q;
   assign virt_cs        = spi_cs | ~virt_sel_q;
   assign spi_miso       = virt_sel_q ? virt_miso : phys_miso;
   assign virt_sel       = virt_sel_q;
   assign switch_pending = pending_q;
   assign switch_done    = done_q;
   assign sd_act         = sd_act_q;
   assign led_virt       = virt_sel_q & sd_act_q;
   assign led_phys       = ~virt_sel_q & sd_act_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Bench for sd_spi_arbiter with SWITCH_GUARD=4 and ACT_TIMEOUT=10.
// Each switch_done pulse is captured and reconciled against the expected switch queue at the end.
module tb_sd_spi_arbiter;

   logic       clk_sys = 1'b0;
   logic       reset = 1'b0;
   logic       img_mounted = 1'b0;
   logic       img_present = 1'b0;
   logic       spi_sck = 1'b0;
   logic       spi_mosi = 1'b0;
   logic       spi_cs = 1'b1;
   logic       spi_miso;
   logic       phys_miso = 1'b0;
   logic       virt_miso = 1'b0;
   logic       phys_sck, phys_mosi, phys_cs, virt_cs;
   logic       virt_sel, switch_pending, switch_done, sd_act;
   logic       led_virt, led_phys;
   logic [1:0] dbg_state;

   int checks = 0;
   int failures = 0;
   logic exp_q[$];
   logic obs_q[$];

   sd_spi_arbiter #(.SWITCH_GUARD(4), .ACT_TIMEOUT(10)) dut (
      .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_present(img_present),
      .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_miso(spi_miso),
      .phys_miso(phys_miso), .virt_miso(virt_miso), .phys_sck(phys_sck), .phys_mosi(phys_mosi),
      .phys_cs(phys_cs), .virt_cs(virt_cs), .virt_sel(virt_sel), .switch_pending(switch_pending),
      .switch_done(switch_done), .sd_act(sd_act), .led_virt(led_virt), .led_phys(led_phys),
      .dbg_state_o(dbg_state)
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) begin
      if (switch_done === 1'b1) obs_q.push_back(virt_sel);
   end

   task automatic cyc();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic pulse_mount(input logic present);
      img_present = present;
      img_mounted = 1'b1;
      cyc();
      img_mounted = 1'b0;
   endtask

   task automatic test_reset();
      spi_cs = 1'b1;
      do_reset();
      @(negedge clk_sys);
      checks++; if (virt_sel !== 1'b0) begin failures++; $display("FAIL reset_virt_sel: got %b want 0", virt_sel); end
      checks++; if (switch_pending !== 1'b0) begin failures++; $display("FAIL reset_pending: got %b want 0", switch_pending); end
      checks++; if (switch_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", switch_done); end
      checks++; if (sd_act !== 1'b1) begin failures++; $display("FAIL reset_sd_act: got %b want 1", sd_act); end
      checks++; if (virt_cs !== 1'b1 || phys_cs !== 1'b1) begin failures++; $display("FAIL reset_cs: got phys=%b virt=%b want 1/1", phys_cs, virt_cs); end
   endtask

   task automatic test_activity();
      logic e;
      spi_mosi = 1'b0; phys_miso = 1'b0; virt_miso = 1'b0;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_sys);
         e = (i < 10);
         checks++; if (sd_act !== e) begin failures++; $display("FAIL act_poweron[%0d]: got %b want %b", i, sd_act, e); end
         checks++; if (led_phys !== e || led_virt !== 1'b0) begin failures++; $display("FAIL act_leds[%0d]: got phys=%b virt=%b want %b/0", i, led_phys, led_virt, e); end
      end
      cyc();
      spi_mosi = 1'b1;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk_sys);
         e = (j >= 1 && j <= 10);
         checks++; if (sd_act !== e) begin failures++; $display("FAIL act_toggle[%0d]: got %b want %b", j, sd_act, e); end
         checks++; if (led_phys !== e) begin failures++; $display("FAIL act_led_phys[%0d]: got %b want %b", j, led_phys, e); end
      end
   endtask

   task automatic test_switch_basic();
      do_reset();
      spi_cs = 1'b1;
      exp_q.push_back(1'b1);
      pulse_mount(1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_sys);
         checks++; if (switch_pending !== 1'b1 || virt_sel !== 1'b0) begin failures++; $display("FAIL basic_drain[%0d]: got pend=%b sel=%b want 1/0", k, switch_pending, virt_sel); end
         cyc();
      end
      @(negedge clk_sys);
      checks++; if (virt_sel !== 1'b1 || switch_done !== 1'b1) begin failures++; $display("FAIL basic_commit: got sel=%b done=%b want 1/1", virt_sel, switch_done); end
      checks++; if (switch_pending !== 1'b0 || phys_cs !== 1'b1) begin failures++; $display("FAIL basic_after: got pend=%b phys_cs=%b want 0/1", switch_pending, phys_cs); end
      cyc();
      @(negedge clk_sys);
      checks++; if (switch_done !== 1'b0 || virt_sel !== 1'b1) begin failures++; $display("FAIL basic_pulse_end: got done=%b sel=%b want 0/1", switch_done, virt_sel); end
      pulse_mount(1'b1);
      @(negedge clk_sys);
      checks++; if (switch_pending !== 1'b0 || switch_done !== 1'b0 || virt_sel !== 1'b1) begin failures++; $display("FAIL same_target: got pend=%b done=%b sel=%b want 0/0/1", switch_pending, switch_done, virt_sel); end
   endtask

   task automatic test_guard_toggle();
      do_reset();
      spi_cs = 1'b1;
      exp_q.push_back(1'b1);
      pulse_mount(1'b1);
      for (int r = 0; r < 3; r++) begin
         for (int p = 0; p < 4; p++) begin
            spi_cs = (p != 3);
            @(negedge clk_sys);
            checks++; if (virt_sel !== 1'b0 || switch_pending !== 1'b1) begin failures++; $display("FAIL toggle_hold[%0d.%0d]: got sel=%b pend=%b want 0/1", r, p, virt_sel, switch_pending); end
            cyc();
         end
      end
      spi_cs = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_sys);
         checks++; if (virt_sel !== 1'b0) begin failures++; $display("FAIL toggle_settle[%0d]: got sel=%b want 0", k, virt_sel); end
         cyc();
      end
      @(negedge clk_sys);
      checks++; if (virt_sel !== 1'b1 || switch_done !== 1'b1) begin failures++; $display("FAIL toggle_commit: got sel=%b done=%b want 1/1", virt_sel, switch_done); end
   endtask

   task automatic test_mount_on_commit();
      do_reset();
      spi_cs = 1'b1;
      exp_q.push_back(1'b1);
      pulse_mount(1'b1);
      cyc(); cyc(); cyc();
      pulse_mount(1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_sys);
         checks++; if (switch_pending !== 1'b1 || virt_sel !== 1'b0 || switch_done !== 1'b0) begin failures++; $display("FAIL commit_suppress[%0d]: got pend=%b sel=%b done=%b want 1/0/0", k, switch_pending, virt_sel, switch_done); end
         cyc();
      end
      @(negedge clk_sys);
      checks++; if (virt_sel !== 1'b1 || switch_done !== 1'b1) begin failures++; $display("FAIL commit_late: got sel=%b done=%b want 1/1", virt_sel, switch_done); end
   endtask

   task automatic test_cancel();
      do_reset();
      spi_cs = 1'b1;
      pulse_mount(1'b1);
      @(negedge clk_sys);
      checks++; if (switch_pending !== 1'b1) begin failures++; $display("FAIL cancel_pend: got %b want 1", switch_pending); end
      pulse_mount(1'b0);
      @(negedge clk_sys);
      checks++; if (switch_pending !== 1'b0 || virt_sel !== 1'b0) begin failures++; $display("FAIL cancel_drop: got pend=%b sel=%b want 0/0", switch_pending, virt_sel); end
      for (int k = 0; k < 8; k++) begin
         cyc();
         @(negedge clk_sys);
         checks++; if (switch_done !== 1'b0 || virt_sel !== 1'b0) begin failures++; $display("FAIL cancel_quiet[%0d]: got done=%b sel=%b want 0/0", k, switch_done, virt_sel); end
      end
   endtask

   task automatic test_routing();
      do_reset();
      spi_cs = 1'b0; spi_sck = 1'b1; spi_mosi = 1'b1; phys_miso = 1'b1; virt_miso = 1'b0;
      @(negedge clk_sys);
      checks++; if ({phys_cs, virt_cs, phys_sck, phys_mosi, spi_miso} !== 5'b01111) begin failures++; $display("FAIL route_phys: got %b want 01111", {phys_cs, virt_cs, phys_sck, phys_mosi, spi_miso}); end
      spi_cs = 1'b1;
      exp_q.push_back(1'b1);
      pulse_mount(1'b1);
      cyc(); cyc(); cyc(); cyc();
      virt_miso = 1'b1; phys_miso = 1'b0; spi_cs = 1'b0;
      @(negedge clk_sys);
      checks++; if (virt_sel !== 1'b1) begin failures++; $display("FAIL route_sel: got %b want 1", virt_sel); end
      checks++; if ({phys_cs, virt_cs, phys_sck, phys_mosi, spi_miso} !== 5'b10001) begin failures++; $display("FAIL route_virt: got %b want 10001", {phys_cs, virt_cs, phys_sck, phys_mosi, spi_miso}); end
      spi_cs = 1'b1;
      #1;
      checks++; if (virt_cs !== 1'b1) begin failures++; $display("FAIL route_virt_cs: got %b want 1", virt_cs); end
      spi_sck = 1'b0;
   endtask

   task automatic test_reset_in_drain();
      do_reset();
      spi_cs = 1'b1;
      pulse_mount(1'b1);
      @(negedge clk_sys);
      checks++; if (switch_pending !== 1'b1) begin failures++; $display("FAIL rdrain_pend: got %b want 1", switch_pending); end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      @(negedge clk_sys);
      checks++; if (switch_pending !== 1'b0 || virt_sel !== 1'b0) begin failures++; $display("FAIL rdrain_clear: got pend=%b sel=%b want 0/0", switch_pending, virt_sel); end
      for (int k = 0; k < 8; k++) begin
         cyc();
         @(negedge clk_sys);
         checks++; if (switch_done !== 1'b0 || virt_sel !== 1'b0) begin failures++; $display("FAIL rdrain_quiet[%0d]: got done=%b sel=%b want 0/0", k, switch_done, virt_sel); end
      end
      reset = 1'b1; img_present = 1'b1; img_mounted = 1'b1;
      cyc();
      reset = 1'b0; img_mounted = 1'b0;
      @(negedge clk_sys);
      checks++; if (switch_pending !== 1'b0) begin failures++; $display("FAIL reset_over_mount: got pend=%b want 0", switch_pending); end
   endtask

   task automatic test_scoreboard();
      logic e, o;
      checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL sb_count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++; if (o !== e) begin failures++; $display("FAIL sb_target: got %b want %b", o, e); end
      end
   endtask

   initial begin
      test_reset();
      test_activity();
      test_switch_basic();
      test_guard_toggle();
      test_mount_on_commit();
      test_cancel();
      test_routing();
      test_reset_in_drain();
      cyc();
      test_scoreboard();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sd_spi_arbiter.md
SD_SPI_ARBITER -- requirements
Module: sd_spi_arbiter

Interface
REQ-001 Parameter SWITCH_GUARD, default 16, consecutive cycles spi_cs must be high before a pending target switch is committed.
REQ-002 Parameter ACT_TIMEOUT, default 1000000, cycles sd_act stays high after the last SPI line toggle.
REQ-003 clk_sys  in  1  system clock; all state on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 img_mounted  in  1  one-cycle pulse, new image mount event.
REQ-006 img_present  in  1  image size nonzero, sampled only when img_mounted=1.
REQ-007 spi_sck, spi_mosi, spi_cs  in  1 each  core-side SPI master; spi_cs high = deselected.
REQ-008 spi_miso  out  1  MISO returned to the core.
REQ-009 phys_miso, virt_miso  in  1 each  MISO from the physical card and the virtual card.
REQ-010 phys_sck, phys_mosi, phys_cs  out  1 each  physical card SPI.
REQ-011 virt_cs  out  1  virtual card select, high = deselected.
REQ-012 virt_sel  out  1  registered current target; 1 = virtual card.
REQ-013 switch_pending  out  1  high while a target change is waiting for bus idle.
REQ-014 switch_done  out  1  one-cycle pulse when a target change commits.
REQ-015 sd_act  out  1  SPI activity indicator.
REQ-016 led_virt, led_phys  out  1 each  activity split by target.

Function
REQ-017 States: PHYS (virt_sel=0), VIRT (virt_sel=1), DRAIN (switch pending, virt_sel holds the old target).
REQ-018 img_mounted with img_present != virt_sel in PHYS/VIRT: latch target=img_present, enter DRAIN, clear guard counter.
REQ-019 img_mounted with img_present == virt_sel in PHYS/VIRT: no state change, no pulse.
REQ-020 DRAIN: guard counter increments each cycle spi_cs=1; clears to 0 on any cycle spi_cs=0.
REQ-021 DRAIN: when the guard counter reaches SWITCH_GUARD-1 with spi_cs=1, virt_sel<=target on the next edge, switch_done=1 for that one cycle, return to PHYS or VIRT.
REQ-022 img_mounted during DRAIN: target overwritten by the latest img_present; guard counter cleared; if the new target equals virt_sel, return to PHYS/VIRT without a switch_done pulse.
REQ-023 img_mounted coinciding with the commit cycle: the mount takes priority; the commit is suppressed and REQ-018/019 are evaluated against the unchanged virt_sel.
REQ-024 switch_pending = (state==DRAIN), registered.
REQ-025 Routing is combinational from the registered virt_sel: phys_cs=spi_cs|virt_sel; phys_sck=spi_sck&~virt_sel; phys_mosi=spi_mosi&~virt_sel; virt_cs=spi_cs|~virt_sel; spi_miso=virt_sel?virt_miso:phys_miso.
REQ-026 The guard counter saturates at SWITCH_GUARD-1 and never wraps; its width is clog2(SWITCH_GUARD)+1.
REQ-027 Activity: register spi_mosi and spi_miso every cycle; on any change of either, clear the activity counter to 0.
REQ-028 Activity counter increments while below ACT_TIMEOUT, then holds; sd_act is registered = (counter < ACT_TIMEOUT).
REQ-029 led_virt = virt_sel & sd_act; led_phys = ~virt_sel & sd_act.

Reset
REQ-030 On reset: state PHYS, virt_sel=0, target=0, guard counter 0, switch_pending=0, switch_done=0.
REQ-031 On reset: activity counter 0 and sd_act=1, giving ACT_TIMEOUT cycles of power-on activity.
REQ-032 Reset asserted during DRAIN discards the pending switch with no switch_done pulse.
REQ-033 reset overrides img_mounted in the same cycle.

Verification
REQ-034 SWITCH_GUARD=4: reset, img_mounted with img_present=1, spi_cs=1 held -> switch_pending=1 for 4 cycles, then virt_sel=1, one switch_done pulse, phys_cs=1.
REQ-035 SWITCH_GUARD=4: mount to virtual while spi_cs toggles 1,1,1,0 repeatedly -> virt_sel remains 0; it commits 4 cycles after spi_cs stays 1.
REQ-036 DRAIN toward virtual, second mount with img_present=0 -> switch_pending drops, no switch_done, virt_sel=0.
REQ-037 virt_sel=1, virt_miso=1, phys_miso=0 -> spi_miso=1, phys_sck=0, phys_mosi=0, virt_cs follows spi_cs.
REQ-038 ACT_TIMEOUT=10: after reset, no SPI toggles -> sd_act=1 for 10 cycles then 0; one spi_mosi toggle -> sd_act high for 10 more cycles, led_phys mirrors it.
REQ-039 reset pulsed two cycles into DRAIN -> virt_sel=0, switch_pending=0, no switch_done thereafter.
